// File: rtl/fwrisc_mem_target.sv
// ----------------------------------------------------------------------------
// fwrisc_mem_target
//
// Responder end of the fwrisc data-memory bus. Holds a word-organised RAM of
// 2**ADDR_WIDTH 32-bit words mapped at BASE_ADDR. It supports byte-strobe
// writes and a fixed number of programmable wait states.
//
// Handshake: the initiator raises dvalid and holds the request stable until
// it samples dready high. The target accepts on a posedge where it is IDLE
// and dvalid = 1. It answers with exactly one dready cycle, which is the
// last edge of the sequence IDLE -> WAIT -> RESP. drdata is meaningful only
// while dready = 1. The edge that leaves RESP never accepts a request.
//
// Parameters:
//   ADDR_WIDTH  - log2 of memory depth in words
//   BASE_ADDR   - byte address of word 0 (4-byte aligned)
//   WAIT_CYCLES - extra cycles between acceptance and dready (0..15)
//
// Ports:
//   clock, reset          - clock and async active-low reset
//   dvalid/daddr/dwdata   - request valid, byte address, write data
//   dwstb/dwrite          - byte-lane strobes, write(1)/read(0)
//   drdata/dready         - response data and one-cycle completion pulse
//   dbg_state             - current FSM state for observation
//   rd_count/wr_count/miss_count - access counters, present only when
//                           FWRISC_MEM_TARGET_STATS_EN is defined
// ----------------------------------------------------------------------------
module fwrisc_mem_target #(
   parameter int unsigned ADDR_WIDTH  = 10,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_CYCLES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        dvalid,
   input  logic [31:0] daddr,
   input  logic [31:0] dwdata,
   input  logic [3:0]  dwstb,
   input  logic        dwrite,
   output logic [31:0] drdata,
   output logic        dready,
   output logic [1:0]  dbg_state
`ifdef FWRISC_MEM_TARGET_STATS_EN
   ,
   output logic [31:0] rd_count,
   output logic [31:0] wr_count,
   output logic [31:0] miss_count
`endif
);

   localparam int unsigned DEPTH   = 1 << ADDR_WIDTH;
   localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] addr_q, wdata_q;
   logic [3:0]  stb_q;
   logic        write_q;
   logic [31:0] drdata_q;
   logic        dready_q;

   logic [31:0] mem [DEPTH];

   logic        accept;
   logic        commit;
   logic [31:0] req_addr, req_wdata;
   logic [3:0]  req_stb;
   logic        req_write;
   logic [32:0] off;
   logic        hit;
   logic [ADDR_WIDTH-1:0] idx;

   // With no wait states the access happens on the acceptance edge itself, so
   // the live request is used. Otherwise the latched copy is used, which makes
   // changes on the bus mid-transaction harmless.
   always_comb begin
      req_addr  = addr_q;
      req_wdata = wdata_q;
      req_stb   = stb_q;
      req_write = write_q;
      if (state_q == ST_IDLE) begin
         req_addr  = daddr;
         req_wdata = dwdata;
         req_stb   = dwstb;
         req_write = dwrite;
      end
   end

   // 33-bit offset: a borrow (address below BASE_ADDR) sets bit 32. This
   // makes any address outside the window a miss in a single compare.
   assign off = {1'b0, req_addr} - {1'b0, BASE_ADDR};
   assign hit = (off >> (ADDR_WIDTH + 2)) == 33'd0;
   assign idx = off[ADDR_WIDTH+1:2];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dvalid) begin
               accept = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = WAIT_LD;
               end
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = ST_RESP;
               commit  = 1'b1;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         stb_q    <= 4'h0;
         write_q  <= 1'b0;
         drdata_q <= 32'h0;
         dready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (accept) begin
            addr_q  <= daddr;
            wdata_q <= dwdata;
            stb_q   <= dwstb;
            write_q <= dwrite;
         end
         if (commit) begin
            dready_q <= 1'b1;
            drdata_q <= (hit && !req_write) ? mem[idx] : 32'h0;
         end else begin
            dready_q <= 1'b0;
            drdata_q <= 32'h0;
         end
      end
   end

   // RAM is deliberately not reset. The reset term blocks a write when reset
   // is already low on what would have been the commit edge.
   always_ff @(posedge clock) begin
      if (reset && commit && hit && req_write) begin
         for (int i = 0; i < 4; i++) begin
            if (req_stb[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
         end
      end
   end

   assign drdata    = drdata_q;
   assign dready    = dready_q;
   assign dbg_state = state_q;

`ifdef FWRISC_MEM_TARGET_STATS_EN
   logic [31:0] rd_cnt_q, wr_cnt_q, miss_cnt_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_cnt_q   <= 32'h0;
         wr_cnt_q   <= 32'h0;
         miss_cnt_q <= 32'h0;
      end else if (commit) begin
         if (!hit)          miss_cnt_q <= miss_cnt_q + 32'd1;
         else if (req_write) wr_cnt_q  <= wr_cnt_q + 32'd1;
         else               rd_cnt_q   <= rd_cnt_q + 32'd1;
      end
   end

   assign rd_count   = rd_cnt_q;
   assign wr_count   = wr_cnt_q;
   assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fwrisc_mem_target.sv
// ----------------------------------------------------------------------------
// Bench for fwrisc_mem_target. Two instances are used: one with no wait
// states and one with five. Requests are driven one at a time. Each expected
// response is predicted from a word-addressed model with the data and the
// completion cycle. Monitors compare these against every dready pulse.
// ----------------------------------------------------------------------------
module tb_fwrisc_mem_target;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int W0 = 0;
  localparam int W1 = 5;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [1:0]  dvalid;
  logic [31:0] daddr, dwdata;
  logic [3:0]  dwstb;
  logic        dwrite;
  logic [31:0] drdata0, drdata1;
  logic        dready0, dready1;
  logic [1:0]  dbg0, dbg1;
`ifdef FWRISC_MEM_TARGET_STATS_EN
  logic [31:0] rdc0, wrc0, msc0, rdc1, wrc1, msc1;
`endif

  fwrisc_mem_target #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(W0)) dut0 (
    .clock(clock), .reset(reset), .dvalid(dvalid[0]), .daddr(daddr),
    .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
    .drdata(drdata0), .dready(dready0), .dbg_state(dbg0)
`ifdef FWRISC_MEM_TARGET_STATS_EN
    , .rd_count(rdc0), .wr_count(wrc0), .miss_count(msc0)
`endif
  );

  fwrisc_mem_target #(.ADDR_WIDTH(10), .BASE_ADDR(BASE), .WAIT_CYCLES(W1)) dut1 (
    .clock(clock), .reset(reset), .dvalid(dvalid[1]), .daddr(daddr),
    .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
    .drdata(drdata1), .dready(dready1), .dbg_state(dbg1)
`ifdef FWRISC_MEM_TARGET_STATS_EN
    , .rd_count(rdc1), .wr_count(wrc1), .miss_count(msc1)
`endif
  );

  // scoreboard state
  logic [31:0] exp_q0[$], exp_q1[$];
  int          cyc_q0[$], cyc_q1[$];
  int          checks = 0;
  int          failures = 0;

  // reference model: memory words keyed by instance*4096 + word index
  logic [31:0] mdl[int];
  int rd_m[2], wr_m[2], miss_m[2];

  function automatic bit in_range(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4096);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      rd_m[i] = 0; wr_m[i] = 0; miss_m[i] = 0;
    end
  endtask

  // Drives one request. The task starts at a negedge and returns at the
  // negedge where dready is seen, with dvalid possibly still high. extra=1
  // means the request is raised during the previous dready cycle. In that
  // case the target must ignore it for one edge. tol=1 disturbs the bus
  // after acceptance.
  task automatic issue(input int sel, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] stb,
                       input bit extra, input bit tol);
    logic [31:0] rsp, w;
    int key, lat;
    bit got;
    rsp = 32'h0;
    key = sel * 4096 + int'((addr - BASE) >> 2);
    if (!in_range(addr)) begin
      miss_m[sel]++;
    end else if (wr) begin
      wr_m[sel]++;
      w = mdl.exists(key) ? mdl[key] : 32'hx;
      for (int i = 0; i < 4; i++) if (stb[i]) w[8*i +: 8] = data[8*i +: 8];
      mdl[key] = w;
    end else begin
      rd_m[sel]++;
      rsp = mdl[key];
    end
    lat = cyc + 1 + int'(extra) + ((sel == 1) ? W1 : W0);
    if (sel == 0) begin exp_q0.push_back(rsp); cyc_q0.push_back(lat); end
    else          begin exp_q1.push_back(rsp); cyc_q1.push_back(lat); end
    daddr = addr; dwdata = data; dwstb = stb; dwrite = wr; dvalid[sel] = 1'b1;
    repeat (1 + int'(extra)) @(posedge clock);
    #1;
    if (tol) begin
      if ($urandom_range(0, 1) == 1) dvalid[sel] = 1'b0;
      daddr = $urandom; dwdata = $urandom; dwstb = 4'($urandom); dwrite = ~dwrite;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clock);
      got = (sel == 1) ? dready1 : dready0;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL timeout_inst%0d actual=no_dready required=dready", sel);
    end
  endtask

  // Request followed by one idle cycle; leaves the bench at an idle negedge.
  task automatic req(input int sel, input bit wr, input logic [31:0] addr,
                     input logic [31:0] data, input logic [3:0] stb);
    issue(sel, wr, addr, data, stb, 1'b0, 1'b0);
    dvalid[sel] = 1'b0;
    @(negedge clock);
  endtask

  // monitors
  always @(negedge clock) begin
    if (reset && dready0) begin : mon0
      logic [31:0] e;
      int c;
      checks++;
      if (exp_q0.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dready0 actual=%h required=no_pulse", drdata0);
      end else begin
        e = exp_q0.pop_front();
        c = cyc_q0.pop_front();
        if (drdata0 !== e || cyc !== c) begin
          failures++;
          $display("FAIL resp0 actual=%h@%0d required=%h@%0d", drdata0, cyc, e, c);
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset && dready1) begin : mon1
      logic [31:0] e;
      int c;
      checks++;
      if (exp_q1.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dready1 actual=%h required=no_pulse", drdata1);
      end else begin
        e = exp_q1.pop_front();
        c = cyc_q1.pop_front();
        if (drdata1 !== e || cyc !== c) begin
          failures++;
          $display("FAIL resp1 actual=%h@%0d required=%h@%0d", drdata1, cyc, e, c);
        end
      end
    end
  end

  initial begin
    logic [31:0] addr, p;
    int idx, pick, n_tx;
    bit ex, tl, wr;

    dvalid = 2'b00; daddr = 32'h0; dwdata = 32'h0; dwstb = 4'h0; dwrite = 1'b0;
    clear_counts();
    repeat (3) @(negedge clock);
    check("reset_dready0", {31'h0, dready0}, 32'h0);
    check("reset_drdata0", drdata0, 32'h0);
    check("reset_dready1", {31'h0, dready1}, 32'h0);
    check("reset_drdata1", drdata1, 32'h0);
    reset = 1'b1;
    @(negedge clock);

    for (int sel = 0; sel < 2; sel++) begin
      // preload the word pool used by random traffic
      for (int i = 0; i < 16; i++)     req(sel, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
      for (int i = 1008; i < 1024; i++) req(sel, 1'b1, BASE + 32'(4 * i), $urandom, 4'hF);
      // full-word write / read
      req(sel, 1'b1, 32'h8000_0010, 32'hCAFE_BABE, 4'hF);
      req(sel, 1'b0, 32'h8000_0010, 32'h0, 4'h0);
      // lane strobes, zero-strobe write, ignored low address bits
      req(sel, 1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF);
      req(sel, 1'b1, 32'h8000_0020, 32'hAAAA_AAAA, 4'b0100);
      req(sel, 1'b0, 32'h8000_0020, 32'h0, 4'h0);
      req(sel, 1'b1, 32'h8000_0020, 32'h5555_5555, 4'b0000);
      req(sel, 1'b0, 32'h8000_0023, 32'h0, 4'h0);
      // out of range: reads return 0, writes drop and must not alias word 0
      req(sel, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
      req(sel, 1'b0, BASE + 32'h1000, 32'h0, 4'h0);
      req(sel, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
      req(sel, 1'b0, BASE, 32'h0, 4'h0);
      // last word
      req(sel, 1'b1, 32'h8000_0FFC, 32'h1234_5678, 4'hF);
      req(sel, 1'b0, 32'h8000_0FFC, 32'h0, 4'h0);

      // random traffic with back-to-back raises and bus disturbance
      n_tx = (sel == 0) ? 60 : 20;
      for (int n = 0; n < n_tx; n++) begin
        if ($urandom_range(0, 9) == 0) begin
          addr = ($urandom_range(0, 1) == 1) ? (BASE + 32'h1000 + 32'($urandom_range(0, 255))) : $urandom;
        end else begin
          pick = $urandom_range(0, 31);
          idx = (pick < 16) ? pick : 992 + pick;
          addr = BASE + 32'(4 * idx) + 32'($urandom_range(0, 3));
        end
        wr = 1'($urandom_range(0, 1));
        ex = (n > 0) && ($urandom_range(0, 3) == 0);
        tl = ($urandom_range(0, 3) == 0);
        if (!ex) begin
          dvalid[sel] = 1'b0;
          @(negedge clock);
        end
        issue(sel, wr, addr, $urandom, 4'($urandom), ex, tl);
      end
      dvalid[sel] = 1'b0;
      @(negedge clock);
    end

    // reset during a write's dready pulse: the committed write persists
    issue(0, 1'b1, BASE + 32'd20, 32'h0BAD_F00D, 4'hF, 1'b0, 1'b0);
    dvalid[0] = 1'b0;
    #2 reset = 1'b0;
    #1 check("rst_pulse_dready0", {31'h0, dready0}, 32'h0);
    @(negedge clock) reset = 1'b1;
    clear_counts();
    @(negedge clock);
    // reset during a read pulse clears drdata immediately
    issue(0, 1'b0, BASE + 32'd20, 32'h0, 4'h0, 1'b0, 1'b0);
    dvalid[0] = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("rst_pulse_drdata0", drdata0, 32'h0);
    check("rst_pulse_dready0b", {31'h0, dready0}, 32'h0);
    @(negedge clock) reset = 1'b1;
    clear_counts();
    @(negedge clock);

    // reset mid-WAIT on the 5-wait instance: the write is abandoned
    p = mdl[4096 + 3];
    daddr = BASE + 32'd12; dwdata = ~p; dwstb = 4'hF; dwrite = 1'b1; dvalid[1] = 1'b1;
    @(posedge clock);
    #1 dvalid[1] = 1'b0;
    repeat (2) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_wait_dready1", {31'h0, dready1}, 32'h0);
    check("rst_wait_drdata1", drdata1, 32'h0);
    @(negedge clock) reset = 1'b1;
    clear_counts();
    @(negedge clock);
    req(1, 1'b0, BASE + 32'd12, 32'h0, 4'h0);
    req(1, 1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);
    req(1, 1'b1, BASE + 32'd12, 32'h0000_00FF, 4'b0001);
    req(0, 1'b0, BASE + 32'd20, 32'h0, 4'h0);

`ifdef FWRISC_MEM_TARGET_STATS_EN
    check("rd_count0", rdc0, 32'(rd_m[0]));
    check("wr_count0", wrc0, 32'(wr_m[0]));
    check("miss_count0", msc0, 32'(miss_m[0]));
    check("rd_count1", rdc1, 32'(rd_m[1]));
    check("wr_count1", wrc1, 32'(wr_m[1]));
    check("miss_count1", msc1, 32'(miss_m[1]));
    force dut0.rd_cnt_q = 32'hFFFF_FFFF;
    #1 release dut0.rd_cnt_q;
    @(negedge clock);
    req(0, 1'b0, BASE + 32'd20, 32'h0, 4'h0);
    check("rd_count0_wrap", rdc0, 32'h0);
`endif

    repeat (20) @(negedge clock);
    check("pending0", 32'(exp_q0.size()), 32'h0);
    check("pending1", 32'(exp_q1.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // hard stop if something wedges the sequence
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
